// File: rtl/audio_pkg.sv
// Shared definitions for the audio DAC playback path.
// Holds the default per-channel sample width, the playback state type and
// the width of the underrun counter, plus a saturating increment helper.
package audio_pkg;

   localparam int SAMPLE_W_DEFAULT = 16;
   localparam int UNDERRUN_W       = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_L,
      SHIFT_L,
      GAP_L,
      SHIFT_R,
      GAP_R
   } state_t;

   function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
      return (v == '1) ? v : v + UNDERRUN_W'(1);
   endfunction

endpackage

// File: rtl/i2s_shifter.sv
// MSB-first serialiser for one I2S channel sample.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a new sample; its MSB is presented on ser this cycle
//   shift      : advance to the next bit (ignored once done)
//   sample     : channel sample to serialise
//   ser        : bit to be registered by the caller this cycle
//   done       : all SAMPLE_W bits have been presented
module i2s_shifter #(
   parameter int SAMPLE_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                shift,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                ser,
   output logic                done
);

   localparam int CNT_W = $clog2(SAMPLE_W) + 1;

   logic [SAMPLE_W-1:0] sr;
   logic [CNT_W-1:0]    cnt;

   // On a load the MSB bypasses the register so the caller can drive it on
   // the same edge that captures the sample; the counter then already
   // accounts for that first bit.
   assign ser  = load ? sample[SAMPLE_W-1] : sr[SAMPLE_W-1];
   assign done = (cnt == CNT_W'(SAMPLE_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= sample << 1;
         cnt <= CNT_W'(1);
      end else if (shift && !done) begin
         sr  <= sr << 1;
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/audio_dac_player.sv
// I2S playback engine: buffers one stereo word from the play core and
// serialises it to the codec, left channel first, with the 1-BCLK I2S delay.
// Frames with no buffered word play silence and bump a saturating counter.
// Ports:
//   i_clk          : inverted AUD_BCLK
//   i_rst_n        : asynchronous active-low reset
//   i_en           : playback enable
//   i_daclrck      : codec LRCK (0 = left, 1 = right)
//   i_audio_valid  : upstream word valid
//   i_audio_data   : {left, right} samples, MSB first
//   o_audio_ready  : buffer can accept a word
//   o_dacdat       : serial data to AUD_DACDAT
//   o_underrun_cnt : frames played without data (saturating)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | disabled, output held low, no words accepted
// WAIT_L  | enabled, waiting for the first left start to align playback
// SHIFT_L | serialising the left sample of the current frame
// GAP_L   | left sample done, output low until right start
// SHIFT_R | serialising the right sample of the current frame
// GAP_R   | right sample done, output low until next left start
module audio_dac_player
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_daclrck,
   input  logic                  i_audio_valid,
   input  logic [2*SAMPLE_W-1:0] i_audio_data,
   output logic                  o_audio_ready,
   output logic                  o_dacdat,
   output logic [UNDERRUN_W-1:0] o_underrun_cnt
);

   state_t                state;
   logic                  lrck_q;
   logic                  buf_full;
   logic [2*SAMPLE_W-1:0] buf_word;
   logic [SAMPLE_W-1:0]   frame_right;

   logic                  left_start;
   logic                  right_start;
   logic                  handshake;
   logic                  go_left;
   logic                  go_right;
   logic                  sh_load;
   logic                  sh_shift;
   logic                  sh_ser;
   logic                  sh_done;
   logic [SAMPLE_W-1:0]   sh_sample;

   assign left_start  = lrck_q & ~i_daclrck;
   assign right_start = ~lrck_q & i_daclrck;

   assign o_audio_ready = ~buf_full & (state != IDLE);
   assign handshake     = i_audio_valid & o_audio_ready;

   // Right starts only count once a left channel has begun, so playback
   // never opens on a right half-frame.
   assign go_left  = i_en & (state != IDLE) & left_start;
   assign go_right = i_en & right_start & ((state == SHIFT_L) || (state == GAP_L));

   assign sh_load  = go_left | go_right;
   assign sh_shift = (state == SHIFT_L || state == SHIFT_R) & ~sh_load;

   // Left sample comes straight from the buffer because the frame register
   // is being written on the same edge; only the right half is kept.
   assign sh_sample = go_left ? (buf_full ? buf_word[2*SAMPLE_W-1:SAMPLE_W] : '0)
                              : frame_right;

   i2s_shifter #(
      .SAMPLE_W (SAMPLE_W)
   ) u_shifter (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .load   (sh_load),
      .shift  (sh_shift),
      .sample (sh_sample),
      .ser    (sh_ser),
      .done   (sh_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         lrck_q         <= 1'b1;
         o_dacdat       <= 1'b0;
         buf_full       <= 1'b0;
         buf_word       <= '0;
         frame_right    <= '0;
         o_underrun_cnt <= '0;
      end else begin
         lrck_q <= i_daclrck;
         if (!i_en) begin
            state    <= IDLE;
            o_dacdat <= 1'b0;
            buf_full <= 1'b0;
         end else begin
            // A word arriving on the left-start edge is never bypassed into
            // the frame starting now; it waits for the following frame.
            if (go_left) begin
               if (buf_full) begin
                  frame_right <= buf_word[SAMPLE_W-1:0];
                  buf_full    <= 1'b0;
               end else begin
                  frame_right    <= '0;
                  o_underrun_cnt <= sat_inc(o_underrun_cnt);
                  if (handshake) begin
                     buf_word <= i_audio_data;
                     buf_full <= 1'b1;
                  end
               end
            end else if (handshake) begin
               buf_word <= i_audio_data;
               buf_full <= 1'b1;
            end

            case (state)
               IDLE: begin
                  state    <= WAIT_L;
                  o_dacdat <= 1'b0;
               end
               WAIT_L, GAP_R: begin
                  if (go_left) begin
                     state    <= SHIFT_L;
                     o_dacdat <= sh_ser;
                  end else begin
                     o_dacdat <= 1'b0;
                  end
               end
               SHIFT_L: begin
                  if (go_left) begin
                     o_dacdat <= sh_ser;
                  end else if (go_right) begin
                     state    <= SHIFT_R;
                     o_dacdat <= sh_ser;
                  end else if (sh_done) begin
                     state    <= GAP_L;
                     o_dacdat <= 1'b0;
                  end else begin
                     o_dacdat <= sh_ser;
                  end
               end
               GAP_L: begin
                  if (go_left) begin
                     state    <= SHIFT_L;
                     o_dacdat <= sh_ser;
                  end else if (go_right) begin
                     state    <= SHIFT_R;
                     o_dacdat <= sh_ser;
                  end else begin
                     o_dacdat <= 1'b0;
                  end
               end
               SHIFT_R: begin
                  if (go_left) begin
                     state    <= SHIFT_L;
                     o_dacdat <= sh_ser;
                  end else if (sh_done) begin
                     state    <= GAP_R;
                     o_dacdat <= 1'b0;
                  end else begin
                     o_dacdat <= sh_ser;
                  end
               end
               default: begin
                  state    <= IDLE;
                  o_dacdat <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
